// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
package serial_addsub_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DIGIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// DIGIT-bit ripple adder slice; cmsb is the carry into the slice MSB, used for overflow.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] t;

  assign t    = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  assign sum  = t[DIGIT-1:0];
  assign cout = t[DIGIT];
  assign cmsb = a[DIGIT-1] ^ b[DIGIT-1] ^ t[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract: one DIGIT-wide slice per cycle, LSB first, result committed after N cycles.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt;
  logic             sub_q, cy;
  logic [DIGIT-1:0] dsum;
  logic             dcout, dcmsb;

  digit_adder #(.DIGIT(DIGIT)) u_dig (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0] ^ {DIGIT{sub_q}}),
    .cin  (cy),
    .sum  (dsum),
    .cout (dcout),
    .cmsb (dcmsb)
  );

  // Partial sum fills from the top so that after N digits it is aligned.
  generate
    if (N == 1) begin : g_one
      assign acc_nxt = dsum;
    end else begin : g_many
      assign acc_nxt = {dsum, acc[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      sub_q    <= 1'b0;
      cy       <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Sum      <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            a_sh  <= A;
            b_sh  <= B;
            sub_q <= Sub;
            cy    <= Sub;
            cnt   <= '0;
            acc   <= '0;
            state <= RUN;
            Busy  <= 1'b1;
          end else begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> DIGIT;
          b_sh <= b_sh >> DIGIT;
          acc  <= acc_nxt;
          cy   <= dcout;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            Sum      <= acc_nxt;
            Carry    <= dcout;
            Overflow <= dcmsb ^ dcout;
            state    <= DONE;
            Busy     <= 1'b0;
            Done     <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at WIDTH=16, DIGIT=4.
module tb_serial_addsub;

  localparam int W = 16;
  localparam int N = 4;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic         Sub = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Busy, Done, Carry, Overflow;
  logic [W-1:0] Sum;

  int checks = 0;
  int fails  = 0;
  logic [W-1:0] prev_sum = '0;

  serial_addsub #(.WIDTH(W), .DIGIT(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Sub(Sub), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Sum(Sum), .Carry(Carry), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference result {ovf, carry, sum} for the back-to-back stream.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, b, input logic s);
    logic [W-1:0] bb;
    logic [W:0]   r;
    logic         v;
    bb = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
    v  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    return {v, r};
  endfunction

  // Called at a negedge; runs one operation and checks the full timeline.
  task automatic op(input string tag, input logic [W-1:0] a, b, input logic s,
                    input logic [W-1:0] es, input logic ec, eo, input logic inj);
    Start = 1'b1; A = a; B = b; Sub = s;
    @(negedge Clk);
    Start = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk({tag, "_busy"}, Busy, 1'b1);
      chk({tag, "_nodone"}, Done, 1'b0);
      chk({tag, "_hold"}, Sum, prev_sum);
      if (inj && i == 1) begin
        Start = 1'b1; A = 16'h00FF; B = 16'h00FF; Sub = 1'b1;
      end else begin
        Start = 1'b0;
      end
      @(negedge Clk);
    end
    Start = 1'b0;
    chk({tag, "_done"}, Done, 1'b1);
    chk({tag, "_busy0"}, Busy, 1'b0);
    chk({tag, "_sum"}, Sum, es);
    chk({tag, "_carry"}, Carry, ec);
    chk({tag, "_ovf"}, Overflow, eo);
    prev_sum = es;
    @(negedge Clk);
    chk({tag, "_pulse"}, Done, 1'b0);
    chk({tag, "_idle"}, Busy, 1'b0);
  endtask

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic s; } vec_t;
  vec_t bb_vec[3];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bb_vec[0] = '{16'h1234, 16'h1111, 1'b0};
    bb_vec[1] = '{16'h0001, 16'h0002, 1'b1};
    bb_vec[2] = '{16'h8000, 16'h8000, 1'b0};

    repeat (2) @(negedge Clk);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_sum", Sum, 16'h0000);
    chk("rst_carry", Carry, 1'b0);
    chk("rst_ovf", Overflow, 1'b0);
    Reset = 1'b0;

    // Start on the very first edge after reset release.
    op("ovf_add",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    op("wrap_add", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    op("neg_sub",  16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    op("ovf_sub",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    op("plain",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    op("zero_sub", 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    op("ignore",   16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1);

    // Continuous Start: Done every N+1 cycles with no IDLE gap.
    Start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      logic [W+1:0] m;
      A = bb_vec[j].a; B = bb_vec[j].b; Sub = bb_vec[j].s;
      m = model(bb_vec[j].a, bb_vec[j].b, bb_vec[j].s);
      @(negedge Clk);
      chk("b2b_busy", Busy, 1'b1);
      chk("b2b_nodone", Done, 1'b0);
      repeat (N - 1) @(negedge Clk);
      chk("b2b_early", Done, 1'b0);
      @(negedge Clk);
      chk("b2b_done", Done, 1'b1);
      chk("b2b_sum", Sum, m[W-1:0]);
      chk("b2b_carry", Carry, m[W]);
      chk("b2b_ovf", Overflow, m[W+1]);
    end
    Start = 1'b0;
    prev_sum = 16'h0000;
    @(negedge Clk);
    chk("b2b_idle", Busy, 1'b0);

    // Abort mid-run with an asynchronous reset just after edge k+2.
    Start = 1'b1; A = 16'hFFFF; B = 16'h0001; Sub = 1'b0;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("abort_busy", Busy, 1'b0);
    chk("abort_done", Done, 1'b0);
    chk("abort_sum", Sum, 16'h0000);
    chk("abort_carry", Carry, 1'b0);
    chk("abort_ovf", Overflow, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    begin
      int dones = 0;
      for (int i = 0; i < N + 2; i++) begin
        @(negedge Clk);
        if (Done === 1'b1 || Busy === 1'b1) dones++;
      end
      chk("abort_quiet", dones, 0);
    end
    prev_sum = 16'h0000;
    op("after_abort", 16'h0100, 16'h0023, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, meaning bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, and N = WIDTH/DIGIT.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port Start, input, 1 bit: request to begin an operation.
REQ-006 The block SHALL have port Sub, input, 1 bit: mode, 0 = A+B, 1 = A-B; sampled with Start.
REQ-007 The block SHALL have ports A and B, input, WIDTH bits each: operands, sampled with Start.
REQ-008 The block SHALL have port Busy, output, 1 bit: an operation is in progress.
REQ-009 The block SHALL have port Done, output, 1 bit: one-cycle pulse marking a new result.
REQ-010 The block SHALL have port Sum, output, WIDTH bits: registered result.
REQ-011 The block SHALL have port Carry, output, 1 bit: carry out of the MSB (for Sub=1, 1 = no borrow).
REQ-012 The block SHALL have port Overflow, output, 1 bit: two's-complement signed overflow.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 Accept rule: Start=1 at rising edge k while in IDLE or DONE SHALL latch A, B and Sub, clear the digit counter, set the internal carry to Sub, and enter RUN.
REQ-015 Start while in RUN SHALL be ignored; latched operands and mode SHALL be unaffected.
REQ-016 In RUN, edge k+1+i (i = 0..N-1) SHALL add digit i of A, digit i of (Sub ? ~B : B) and the internal carry, LSB digit first, and store the partial sum and carry.
REQ-017 At edge k+N, the block SHALL commit Sum, Carry and Overflow, enter DONE and assert Done for exactly one cycle; latency from accept to Done is N cycles.
REQ-018 Overflow SHALL equal carry-into-MSB XOR carry-out-of-MSB of the full-width operation.
REQ-019 Busy SHALL be 1 exactly in RUN.
REQ-020 Sum, Carry and Overflow SHALL hold their last committed value through IDLE, RUN and DONE until the next commit; partial results SHALL never appear on Sum.
REQ-021 DONE SHALL return to IDLE at the next edge unless Start=1, in which case a back-to-back accept occurs (REQ-014).
REQ-022 Start and Sub SHALL be level-sampled only at edges; no edge detection.
REQ-023 For DIGIT = WIDTH (N=1), RUN SHALL last one cycle and all rules above SHALL still hold.

Reset
REQ-024 Reset=1 SHALL immediately force IDLE, with Busy=0, Done=0, Sum=0, Carry=0 and Overflow=0, and clear the counter, internal carry and latched operands.
REQ-025 Reset asserted mid-RUN SHALL abort the operation; no Done SHALL follow after reset releases.
REQ-026 Start sampled at the first edge after reset deasserts SHALL be accepted normally.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the defaults WIDTH_DEF=16 and DIGIT_DEF=4.
REQ-028 One sub-module digit_adder (DIGIT-bit combinational adder with carry-in, carry-out and carry-into-MSB) SHALL be instantiated once; the top block holds the FSM, counter and shift registers.
REQ-029 The digit counter width SHALL be clog2(N) with a minimum of 1 bit.

Verification (WIDTH=16, DIGIT=4, N=4)
REQ-030 Start, A=16'h7FFF, B=16'h0001, Sub=0 -> Busy for 4 cycles, Done pulse at edge k+4, Sum=16'h8000, Carry=0, Overflow=1.
REQ-031 A=16'hFFFF, B=16'h0001, Sub=0 -> Sum=16'h0000, Carry=1, Overflow=0.
REQ-032 A=16'h0003, B=16'h0005, Sub=1 -> Sum=16'hFFFE, Carry=0, Overflow=0; A=16'h8000, B=16'h0001, Sub=1 -> Sum=16'h7FFF, Carry=1, Overflow=1.
REQ-033 Start A=1, B=2 in cycle k, then Start A=16'h00FF, B=16'h00FF at k+2 while Busy -> ignored; Sum=16'h0003 at k+4.
REQ-034 Start asserted continuously -> Done every 5 cycles, back-to-back from DONE with no IDLE cycle, results match a reference model.
REQ-035 Reset asserted at k+2 mid-RUN -> outputs 0 immediately, no Done after release, and the next Start completes correctly.
